// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : 8-phase machine-cycle sequencer. Fetches an instruction as two
//            nibbles, decodes it and issues per-phase datapath strobes.
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer #(
  parameter int DATA_W    = 4,
  parameter int REG_SEL_W = 4
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 hold,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 cond_true,
  output logic [2:0]           phase,
  output logic                 sync,
  output logic                 dbb_enable,
  output logic [1:0]           dbb_dir,
  output logic                 ir_we_hi,
  output logic                 ir_we_lo,
  output logic                 second_word,
  output logic                 temp_we,
  output logic                 acc_we,
  output logic                 index_we,
  output logic [REG_SEL_W-1:0] index_sel,
  output logic                 alu_enable,
  output logic [2:0]           alu_op,
  output logic [DATA_W-1:0]    imm,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic                 pc_pop,
  output logic                 illegal
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0, PH_A2 = 3'd1, PH_A3 = 3'd2, PH_M1 = 3'd3,
    PH_M2 = 3'd4, PH_X1 = 3'd5, PH_X2 = 3'd6, PH_X3 = 3'd7
  } phase_e;

  localparam logic [3:0] c_op_nop = 4'b0000;
  localparam logic [3:0] c_op_jcn = 4'b0001;
  localparam logic [3:0] c_op_fim = 4'b0010;
  localparam logic [3:0] c_op_jun = 4'b0100;
  localparam logic [3:0] c_op_inc = 4'b0110;
  localparam logic [3:0] c_op_add = 4'b1000;
  localparam logic [3:0] c_op_sub = 4'b1001;
  localparam logic [3:0] c_op_ld  = 4'b1010;
  localparam logic [3:0] c_op_xch = 4'b1011;
  localparam logic [3:0] c_op_bbl = 4'b1100;
  localparam logic [3:0] c_op_ldm = 4'b1101;

  localparam logic [2:0] c_alu_add  = 3'd0;
  localparam logic [2:0] c_alu_sub  = 3'd1;
  localparam logic [2:0] c_alu_inc  = 3'd2;
  localparam logic [2:0] c_alu_temp = 3'd3;
  localparam logic [2:0] c_alu_imm  = 3'd4;

  localparam logic [REG_SEL_W-1:0] c_sel_lsb = REG_SEL_W'(1);

  phase_e              phase_q, phase_d;
  logic [DATA_W-1:0]   opr_q, opr_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opnd_hi_q, opnd_hi_d;
  logic [DATA_W-1:0]   opnd_lo_q, opnd_lo_d;
  logic                sw_q, sw_d;

  logic [3:0]           w_op;
  logic                 w_is_fim;
  logic                 w_two_word;
  logic [REG_SEL_W-1:0] w_sel;

  assign w_op       = opr_q[3:0];
  assign w_is_fim   = (w_op == c_op_fim) && !opa_q[0];
  assign w_two_word = w_is_fim || (w_op == c_op_jun) || (w_op == c_op_jcn);
  assign w_sel      = opa_q[REG_SEL_W-1:0];

  always_ff @(posedge clk_2) begin
    if (reset) begin
      phase_q   <= PH_A1;
      opr_q     <= '0;
      opa_q     <= '0;
      opnd_hi_q <= '0;
      opnd_lo_q <= '0;
      sw_q      <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      opr_q     <= opr_d;
      opa_q     <= opa_d;
      opnd_hi_q <= opnd_hi_d;
      opnd_lo_q <= opnd_lo_d;
      sw_q      <= sw_d;
    end
  end

  // Nothing advances or latches while stalled, so the held phase replays intact.
  always_comb begin
    phase_d   = phase_q;
    opr_d     = opr_q;
    opa_d     = opa_q;
    opnd_hi_d = opnd_hi_q;
    opnd_lo_d = opnd_lo_q;
    sw_d      = sw_q;
    if (!hold) begin
      phase_d = phase_e'(phase_q + 3'd1);
      case (phase_q)
        PH_M1: begin
          if (sw_q) opnd_hi_d = data_in;
          else      opr_d     = data_in;
        end
        PH_M2: begin
          if (sw_q) opnd_lo_d = data_in;
          else      opa_d     = data_in;
        end
        PH_X3: begin
          if (sw_q)            sw_d = 1'b0;
          else if (w_two_word) sw_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sync       = 1'b0;
    dbb_enable = 1'b0;
    dbb_dir    = 2'd0;
    ir_we_hi   = 1'b0;
    ir_we_lo   = 1'b0;
    temp_we    = 1'b0;
    acc_we     = 1'b0;
    index_we   = 1'b0;
    index_sel  = '0;
    alu_enable = 1'b0;
    alu_op     = c_alu_add;
    imm        = '0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_pop     = 1'b0;
    illegal    = 1'b0;
    if (!reset && !hold) begin
      sync = (phase_q == PH_X3);
      case (phase_q)
        PH_A1, PH_A2, PH_A3: begin
          dbb_enable = 1'b1;
          dbb_dir    = 2'd1;
        end
        PH_M1: begin
          dbb_enable = 1'b1;
          dbb_dir    = 2'd2;
          ir_we_hi   = !sw_q;
        end
        PH_M2: begin
          dbb_enable = 1'b1;
          dbb_dir    = 2'd2;
          ir_we_lo   = !sw_q;
          pc_inc     = 1'b1;
        end
        default: begin
          if (sw_q) begin
            // Second cycle acts on the opcode latched by the first word.
            if (w_is_fim) begin
              if (phase_q == PH_X2) begin
                index_we  = 1'b1;
                index_sel = w_sel & ~c_sel_lsb;
                imm       = opnd_hi_q;
              end else if (phase_q == PH_X3) begin
                index_we  = 1'b1;
                index_sel = w_sel | c_sel_lsb;
                imm       = opnd_lo_q;
              end
            end else if (w_op == c_op_jun) begin
              pc_load = (phase_q == PH_X3);
            end else if (w_op == c_op_jcn) begin
              pc_load = (phase_q == PH_X3) && cond_true;
            end
          end else begin
            case (w_op)
              c_op_add, c_op_sub: begin
                index_sel = w_sel;
                temp_we   = (phase_q == PH_X1);
                if (phase_q == PH_X2) begin
                  alu_enable = 1'b1;
                  alu_op     = (w_op == c_op_sub) ? c_alu_sub : c_alu_add;
                  acc_we     = 1'b1;
                end
              end
              c_op_ld: begin
                index_sel = w_sel;
                temp_we   = (phase_q == PH_X1);
                if (phase_q == PH_X2) begin
                  alu_op = c_alu_temp;
                  acc_we = 1'b1;
                end
              end
              c_op_xch: begin
                index_sel = w_sel;
                temp_we   = (phase_q == PH_X1);
                if (phase_q == PH_X2) begin
                  index_we   = 1'b1;
                  dbb_enable = 1'b1;
                  dbb_dir    = 2'd3;
                end else if (phase_q == PH_X3) begin
                  alu_op = c_alu_temp;
                  acc_we = 1'b1;
                end
              end
              c_op_inc: begin
                index_sel = w_sel;
                temp_we   = (phase_q == PH_X1);
                if (phase_q == PH_X2) begin
                  alu_op   = c_alu_inc;
                  index_we = 1'b1;
                end
              end
              c_op_ldm, c_op_bbl: begin
                if (phase_q == PH_X2) begin
                  alu_op = c_alu_imm;
                  imm    = opa_q;
                  acc_we = 1'b1;
                end
                pc_pop = (w_op == c_op_bbl) && (phase_q == PH_X3);
              end
              c_op_nop, c_op_jun, c_op_jcn: ;
              c_op_fim: illegal = opa_q[0] && (phase_q == PH_X1);
              default:  illegal = (phase_q == PH_X1);
            endcase
          end
        end
      endcase
    end
  end

  assign phase       = phase_q;
  assign second_word = sw_q;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Directed plus randomized bench for control_sequencer against an
//            instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  localparam int DATA_W    = 4;
  localparam int REG_SEL_W = 4;

  logic                 clk_2 = 1'b0;
  logic                 reset, hold, cond_true;
  logic [DATA_W-1:0]    data_in;
  logic [2:0]           phase;
  logic                 sync, dbb_enable;
  logic [1:0]           dbb_dir;
  logic                 ir_we_hi, ir_we_lo, second_word;
  logic                 temp_we, acc_we, index_we;
  logic [REG_SEL_W-1:0] index_sel;
  logic                 alu_enable;
  logic [2:0]           alu_op;
  logic [DATA_W-1:0]    imm;
  logic                 pc_inc, pc_load, pc_pop, illegal;

  control_sequencer #(.DATA_W(DATA_W), .REG_SEL_W(REG_SEL_W)) dut (
    .clk_2(clk_2), .reset(reset), .hold(hold), .data_in(data_in),
    .cond_true(cond_true), .phase(phase), .sync(sync),
    .dbb_enable(dbb_enable), .dbb_dir(dbb_dir), .ir_we_hi(ir_we_hi),
    .ir_we_lo(ir_we_lo), .second_word(second_word), .temp_we(temp_we),
    .acc_we(acc_we), .index_we(index_we), .index_sel(index_sel),
    .alu_enable(alu_enable), .alu_op(alu_op), .imm(imm), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_pop(pc_pop), .illegal(illegal)
  );

  always #5 clk_2 = ~clk_2;

  int checks   = 0;
  int failures = 0;

  // Instruction-level model state
  int         m_phase;
  logic [3:0] m_opr, m_opa, m_hi, m_lo;
  bit         m_sw;

  int n_temp, n_acc, n_idx, n_alu, n_load, n_pop, n_ill, n_sync;

  function automatic string mnemonic(input logic [3:0] o, input logic [3:0] a);
    case (o)
      4'h0: return "NOP";
      4'h1: return "JCN";
      4'h2: return a[0] ? "ILL" : "FIM";
      4'h4: return "JUN";
      4'h6: return "INC";
      4'h8: return "ADD";
      4'h9: return "SUB";
      4'hA: return "LD";
      4'hB: return "XCH";
      4'hC: return "BBL";
      4'hD: return "LDM";
      default: return "ILL";
    endcase
  endfunction

  task automatic clr_counts();
    n_temp = 0; n_acc = 0; n_idx = 0; n_alu = 0;
    n_load = 0; n_pop = 0; n_ill = 0; n_sync = 0;
  endtask

  task automatic model_reset();
    m_phase = 0; m_opr = 0; m_opa = 0; m_hi = 0; m_lo = 0; m_sw = 0;
  endtask

  task automatic predict(output logic [28:0] ev, output logic [28:0] cv);
    logic syn, den, ih, il, tw, aw, iw, ae, pi, pl, pp, ill;
    logic csel, cimm, cop;
    logic [1:0] dd;
    logic [3:0] sel, im;
    logic [2:0] op;
    string mn;
    int x;
    {syn, den, ih, il, tw, aw, iw, ae, pi, pl, pp, ill} = '0;
    {csel, cimm, cop} = '0;
    dd = 0; sel = 0; im = 0; op = 0;
    mn = mnemonic(m_opr, m_opa);
    x  = m_phase - 4;
    if (!reset && !hold) begin
      syn = (m_phase == 7);
      if (m_phase <= 2) begin
        den = 1; dd = 2'd1;
      end else if (m_phase <= 4) begin
        den = 1; dd = 2'd2;
        ih = (m_phase == 3) && !m_sw;
        il = (m_phase == 4) && !m_sw;
        pi = (m_phase == 4);
      end else if (!m_sw) begin
        if (x == 1) begin
          if (mn == "ADD" || mn == "SUB" || mn == "LD" || mn == "XCH" || mn == "INC") begin
            tw = 1; sel = m_opa; csel = 1;
          end
          if (mn == "ILL") ill = 1;
        end else if (x == 2) begin
          if (mn == "ADD" || mn == "SUB") begin
            ae = 1; aw = 1; cop = 1; op = (mn == "SUB") ? 3'd1 : 3'd0;
          end else if (mn == "LD") begin
            aw = 1; cop = 1; op = 3'd3;
          end else if (mn == "XCH") begin
            iw = 1; sel = m_opa; csel = 1; den = 1; dd = 2'd3;
          end else if (mn == "INC") begin
            iw = 1; sel = m_opa; csel = 1; cop = 1; op = 3'd2;
          end else if (mn == "LDM" || mn == "BBL") begin
            aw = 1; cop = 1; op = 3'd4; im = m_opa; cimm = 1;
          end
        end else begin
          if (mn == "XCH") begin
            aw = 1; cop = 1; op = 3'd3;
          end
          if (mn == "BBL") pp = 1;
        end
      end else begin
        if (mn == "FIM" && x >= 2) begin
          iw = 1; csel = 1; cimm = 1;
          sel = {m_opa[3:1], (x == 3)};
          im  = (x == 2) ? m_hi : m_lo;
        end
        if (mn == "JUN" && x == 3) pl = 1;
        if (mn == "JCN" && x == 3) pl = cond_true;
      end
    end
    ev = {3'(m_phase), syn, den, dd, ih, il, m_sw, tw, aw, iw, sel, ae, op, im, pi, pl, pp, ill};
    cv = {3'b111, 1'b1, 1'b1, 2'b11, 6'b111111, {4{csel}}, 1'b1, {3{cop}}, {4{cimm}}, 4'b1111};
  endtask

  task automatic advance();
    string mn;
    mn = mnemonic(m_opr, m_opa);
    if (reset) begin
      model_reset();
    end else if (!hold) begin
      if (m_phase == 3) begin
        if (m_sw) m_hi = data_in; else m_opr = data_in;
      end
      if (m_phase == 4) begin
        if (m_sw) m_lo = data_in; else m_opa = data_in;
      end
      if (m_phase == 7) begin
        if (m_sw) m_sw = 0;
        else      m_sw = (mn == "FIM" || mn == "JUN" || mn == "JCN");
      end
      m_phase = (m_phase + 1) % 8;
    end
  endtask

  // One clock: drive, compare against the model mid-cycle, then step the model.
  task automatic cyc(input bit r, input bit h, input logic [3:0] d, input bit c);
    logic [28:0] ev, cv, av;
    reset = r; hold = h; data_in = d; cond_true = c;
    @(negedge clk_2);
    predict(ev, cv);
    av = {phase, sync, dbb_enable, dbb_dir, ir_we_hi, ir_we_lo, second_word,
          temp_we, acc_we, index_we, index_sel, alu_enable, alu_op, imm,
          pc_inc, pc_load, pc_pop, illegal};
    checks++;
    assert (((av ^ ev) & cv) === 29'd0) else begin
      failures++;
      $error("FAIL outputs phase=%0d observed=%h expected=%h care=%h", m_phase, av, ev, cv);
    end
    n_temp += int'(temp_we);  n_acc  += int'(acc_we);
    n_idx  += int'(index_we); n_alu  += int'(alu_enable);
    n_load += int'(pc_load);  n_pop  += int'(pc_pop);
    n_ill  += int'(illegal);  n_sync += int'(sync);
    @(posedge clk_2);
    advance();
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One machine cycle; optionally stalls hl cycles on entering phase hp.
  task automatic instr(input logic [3:0] hi, input logic [3:0] lo, input bit c,
                       input int hp, input int hl);
    for (int k = 0; k < 8; k++) begin
      if (m_phase == hp)
        for (int j = 0; j < hl; j++) cyc(1'b0, 1'b1, 4'($urandom), c);
      cyc(1'b0, 1'b0, (m_phase == 3) ? hi : (m_phase == 4) ? lo : 4'($urandom), c);
    end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; data_in = '0; cond_true = 1'b0;
    @(posedge clk_2); #1;
    model_reset();
    clr_counts();

    cyc(1'b1, 1'b0, 4'h8, 1'b0);
    cyc(1'b1, 1'b1, 4'h3, 1'b1);
    cyc(1'b1, 1'b0, 4'hF, 1'b0);
    chk("reset_phase", int'(phase), 0);
    chk("reset_second_word", int'(second_word), 0);

    clr_counts();
    instr(4'h0, 4'h0, 1'b0, -1, 0);
    chk("nop_sync_count", n_sync, 1);
    chk("nop_wrap_phase", int'(phase), 0);

    clr_counts();
    instr(4'h8, 4'h3, 1'b0, -1, 0);
    chk("add_temp_we", n_temp, 1);
    chk("add_acc_we", n_acc, 1);
    chk("add_alu_enable", n_alu, 1);

    clr_counts();
    instr(4'hD, 4'h5, 1'b0, -1, 0);
    chk("ldm_acc_we", n_acc, 1);
    chk("ldm_no_pop", n_pop, 0);
    clr_counts();
    instr(4'hC, 4'h2, 1'b0, -1, 0);
    chk("bbl_pc_pop", n_pop, 1);

    clr_counts();
    instr(4'h2, 4'h4, 1'b0, -1, 0);
    chk("fim_second_word_set", int'(second_word), 1);
    instr(4'hA, 4'h7, 1'b0, -1, 0);
    chk("fim_index_we", n_idx, 2);
    chk("fim_second_word_clr", int'(second_word), 0);

    clr_counts();
    instr(4'h1, 4'h4, 1'b0, -1, 0);
    instr(4'h5, 4'h6, 1'b0, -1, 0);
    chk("jcn_false_no_load", n_load, 0);
    clr_counts();
    instr(4'h1, 4'h4, 1'b1, -1, 0);
    instr(4'h5, 4'h6, 1'b1, -1, 0);
    chk("jcn_true_load", n_load, 1);

    clr_counts();
    instr(4'h1, 4'h4, 1'b1, -1, 0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 4'h9, 1'b1);
    cyc(1'b1, 1'b0, 4'h5, 1'b1);
    chk("abort_phase", int'(phase), 0);
    chk("abort_second_word", int'(second_word), 0);
    instr(4'h0, 4'h0, 1'b1, -1, 0);
    chk("abort_no_load", n_load, 0);

    clr_counts();
    instr(4'hB, 4'h2, 1'b0, 6, 4);
    chk("xch_hold_index_we_once", n_idx, 1);
    chk("xch_acc_we", n_acc, 1);

    clr_counts();
    instr(4'hF, 4'h0, 1'b0, -1, 0);
    chk("illegal_pulse", n_ill, 1);

    for (int k = 0; k < 1200; k++)
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 12),
          4'($urandom), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

Parametrised successor to the 4004 control unit: an 8-phase machine-cycle sequencer that fetches an 8-bit instruction as two nibbles from the data bus and decodes it. It drives per-phase strobes into the data-bus buffer, ALU, accumulator, temp register, index register file and program counter. It adds a generalised index-register width, two-word instructions (FIM, JUN, JCN), a SYNC output, a hold/stall input and illegal-opcode flagging. It sits between the ROM data bus and the datapath.

## Interface
- DATA_W, 4, data-bus / accumulator nibble width (≥4)
- REG_SEL_W, 4, index-register select width (≤ DATA_W); registers addressed by opa[REG_SEL_W-1:0]
- clk_2  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- hold  in  1  stall: phase frozen and all strobes 0 while high
- data_in  in  DATA_W  nibble from data bus (sampled in M1/M2)
- cond_true  in  1  JCN condition result from datapath
- phase  out  3  A1=0 A2=1 A3=2 M1=3 M2=4 X1=5 X2=6 X3=7
- sync  out  1  high during X3
- dbb_enable  out  1  data-bus buffer drive enable
- dbb_dir  out  2  0=idle, 1=addr out (A1–A3), 2=in (M1,M2), 3=acc out
- ir_we_hi / ir_we_lo  out  1 each  instruction nibble strobes (M1 / M2, first word only)
- second_word  out  1  current machine cycle fetches the 2nd word
- temp_we, acc_we, index_we  out  1 each  register write strobes
- index_sel  out  REG_SEL_W  index-register address
- alu_enable  out  1; alu_op  out  3  0=ADD 1=SUB 2=INC 3=PASS_TEMP 4=PASS_IMM
- imm  out  DATA_W  immediate (opa, or operand nibble for FIM)
- pc_inc, pc_load, pc_pop  out  1 each  program-counter controls
- illegal  out  1  one-cycle pulse at X1 on undefined opcode

## Operation
- Phase counter 0→7 wraps, +1 per clk_2 unless hold. All strobes are combinational functions of (phase, opr, opa, second_word, cond_true), gated to 0 by hold.
- A1–A3: dbb_enable=1, dbb_dir=1. M1: dbb_dir=2, latch data_in→opr (ir_we_hi) or →operand_hi if second_word. M2: same into opa/operand_lo; pc_inc=1 in every machine cycle.
- X-phase behaviour (first word unless noted):
  - 1000 ADD Rn: X1 temp_we, index_sel=opa. X2 alu_enable, alu_op=ADD, acc_we.
  - 1001 SUB: as ADD with alu_op=SUB.
  - 1010 LD: X1 temp_we. X2 alu_op=PASS_TEMP, acc_we.
  - 1011 XCH: X1 temp_we. X2 index_we, dbb_dir=3. X3 alu_op=PASS_TEMP, acc_we.
  - 0110 INC: X1 temp_we. X2 alu_op=INC, index_we.
  - 1101 LDM: X2 alu_op=PASS_IMM, imm=opa, acc_we.
  - 1100 BBL: X2 as LDM. X3 pc_pop.
  - 0010 opa even FIM: two-word. Second cycle: X2 index_we sel=opa&~1 imm=operand_hi; X3 index_we sel=opa|1 imm=operand_lo.
  - 0100 JUN: two-word. Second cycle X3 pc_load.
  - 0001 JCN: two-word. Second cycle X3 pc_load only if cond_true sampled at X3.
  - 0000 NOP: no X strobes.
  - All others: illegal=1 at X1, otherwise NOP.
- second_word sets at X3 of a first-word two-word opcode; clears at X3 of the second cycle. No instruction decode in the second cycle.

## Timing
- Reset (synchronous): next edge phase=A1, opr=opa=operand=0, second_word=0. All strobes 0 during reset, with reset priority over hold. Reset mid-instruction or between words aborts it; no partial X strobe follows.
- Decode latency: opr/opa are valid from M2+1 (X1). X strobes are in the same cycle as their phase.
- hold asserted in phase P: phase stays P and strobes are 0. On release, phase P re-executes in full (strobes for P issued once, after release).
- sync = (phase==7 && !hold && !reset).
- Machine cycle = 8 clk_2 cycles, or 16 for two-word instructions.

## Test plan
- Reset 3 cycles, release → phase 0,1,…,7,0; sync high only at phase 7; all strobes 0 during reset.
- data_in M1=8, M2=3 (ADD R3) → X1 temp_we, index_sel=3; X2 alu_op=0, acc_we; no other strobes.
- LDM 5 (D,5) → X2 imm=5, alu_op=4, acc_we=1; BBL 2 additionally gives pc_pop at X3.
- FIM R4 with operand A,7 → second_word=1 for cycle 2; X2 index_we sel=4 imm=A; X3 sel=5 imm=7.
- JCN with cond_true=0 → no pc_load; repeat with cond_true=1 → pc_load at second-cycle X3. Reset asserted at second-cycle M1 → second_word=0, phase=0, no pc_load.
- hold at X2 of XCH for 4 cycles → phase stays 6, strobes 0; on release index_we fires once. Opcode F,0 → illegal pulse at X1 only.
